// File: rtl/frame_sync.sv
// frame_sync: locates a 32-bit attached sync marker at any of 8 bit offsets
// and either polarity in an unpacked byte stream. A SEARCH/CHECK/LOCK
// flywheel confirms the marker and tracks it. While locked, the block emits
// byte-aligned, polarity-corrected payload bytes with SOF/EOF strobes.
module frame_sync #(
  parameter logic [31:0] ASM       = 32'h1ACFFC1D,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned MAX_ERR   = 2,
  parameter int unsigned CHECK_CNT = 2,
  parameter int unsigned MISS_CNT  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_inv_en,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_lock,
  output logic       o_inverted,
  output logic [2:0] o_offset
);

  typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCK} state_t;

  localparam logic [15:0] LP_EVAL_CNT  = 16'(FRAME_LEN + 4);
  localparam logic [15:0] LP_FRAME_LEN = 16'(FRAME_LEN);
  localparam logic [5:0]  LP_MAX_ERR   = 6'(MAX_ERR);
  localparam logic [7:0]  LP_CHECK_CNT = 8'(CHECK_CNT);
  localparam logic [7:0]  LP_MISS_CNT  = 8'(MISS_CNT);

  // The 39-bit window is {history, incoming byte}; only the 31 bits that
  // survive the next shift are stored, and the distances are taken from the
  // updated window so they register in the same edge as the shift.
  logic [30:0] r_sr;
  logic [38:0] w_win;
  logic [5:0]  w_dist_n [8];
  logic [5:0]  w_dist_i [8];
  logic [5:0]  r_dist_n [8];
  logic [5:0]  r_dist_i [8];
  logic        r_s1_valid;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_confirm;
  logic [7:0]  r_miss;
  logic [7:0]  r_data;
  logic        r_data_valid;
  logic        r_sof;
  logic        r_eof;
  logic        r_lock;
  logic        r_inverted;
  logic [2:0]  r_offset;

  logic        w_srch_hit;
  logic [2:0]  w_srch_k;
  logic        w_srch_inv;
  logic [5:0]  w_mk_dist;
  logic        w_mk_hit;
  logic [15:0] w_cnt_inc;
  logic [7:0]  w_confirm_inc;
  logic [7:0]  w_miss_inc;
  logic [7:0]  w_byte;

  assign w_win = {r_sr, i_data};

  for (genvar g = 0; g < 8; g++) begin : g_dist
    assign w_dist_n[g] = 6'($countones(w_win[g +: 32] ^ ASM));
    assign w_dist_i[g] = 6'($countones(w_win[g +: 32] ^ ~ASM));
  end

  // Stage 1: shift the window and register per-offset marker distances.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr       <= '0;
      r_dist_n   <= '{default: '0};
      r_dist_i   <= '{default: '0};
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= i_data_valid;
      if (i_data_valid) begin
        r_sr     <= w_win[30:0];
        r_dist_n <= w_dist_n;
        r_dist_i <= w_dist_i;
      end
    end
  end

  // Exact-match search: scanning from k=7 down with inverted first lets the
  // last write win, so normal polarity and then the lowest offset take priority.
  always_comb begin
    w_srch_hit = 1'b0;
    w_srch_k   = '0;
    w_srch_inv = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i_inv_en && (r_dist_i[3'(7 - i)] == '0)) begin
        w_srch_hit = 1'b1;
        w_srch_k   = 3'(7 - i);
        w_srch_inv = 1'b1;
      end
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (r_dist_n[3'(7 - i)] == '0) begin
        w_srch_hit = 1'b1;
        w_srch_k   = 3'(7 - i);
        w_srch_inv = 1'b0;
      end
    end
  end

  // Marker check and payload extraction use only the latched offset/polarity.
  always_comb begin
    w_mk_dist     = r_inverted ? r_dist_i[r_offset] : r_dist_n[r_offset];
    w_mk_hit      = (w_mk_dist <= LP_MAX_ERR);
    w_cnt_inc     = r_cnt + 16'd1;
    w_confirm_inc = r_confirm + 8'd1;
    w_miss_inc    = r_miss + 8'd1;
    w_byte        = r_sr[r_offset +: 8] ^ {8{r_inverted}};
  end

  // Stage 2: flywheel state machine, frame counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_SEARCH;
      r_cnt        <= '0;
      r_confirm    <= '0;
      r_miss       <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_lock       <= 1'b0;
      r_inverted   <= 1'b0;
      r_offset     <= '0;
    end else begin
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      if (r_s1_valid) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_srch_hit) begin
              r_offset   <= w_srch_k;
              r_inverted <= w_srch_inv;
              r_cnt      <= '0;
              r_confirm  <= '0;
              r_state    <= ST_CHECK;
            end
          end
          default: begin
            if (w_cnt_inc == LP_EVAL_CNT) begin
              r_cnt <= '0;
              if (r_state == ST_CHECK) begin
                if (w_mk_hit) begin
                  r_confirm <= w_confirm_inc;
                  if (w_confirm_inc == LP_CHECK_CNT) begin
                    r_state <= ST_LOCK;
                    r_lock  <= 1'b1;
                    r_miss  <= '0;
                  end
                end else begin
                  r_state   <= ST_SEARCH;
                  r_confirm <= '0;
                  r_miss    <= '0;
                end
              end else if (w_mk_hit) begin
                r_miss <= '0;
              end else if (w_miss_inc == LP_MISS_CNT) begin
                r_state   <= ST_SEARCH;
                r_lock    <= 1'b0;
                r_confirm <= '0;
                r_miss    <= '0;
              end else begin
                r_miss <= w_miss_inc;
              end
            end else begin
              r_cnt <= w_cnt_inc;
              if ((r_state == ST_LOCK) && (w_cnt_inc <= LP_FRAME_LEN)) begin
                r_data       <= w_byte;
                r_data_valid <= 1'b1;
                r_sof        <= (w_cnt_inc == 16'd1);
                r_eof        <= (w_cnt_inc == LP_FRAME_LEN);
              end
            end
          end
        endcase
      end
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_sof        = r_sof;
  assign o_eof        = r_eof;
  assign o_lock       = r_lock;
  assign o_inverted   = r_inverted;
  assign o_offset     = r_offset;

endmodule

// File: tb/tb_frame_sync.sv
// Bench for frame_sync: builds bit streams of (payload, marker) frames at a
// chosen bit offset/polarity, drives them byte-wise and scoreboards payload.
module tb_frame_sync;

  localparam int FL = 16;
  localparam logic [31:0] ASM_W = 32'h1ACFFC1D;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_inv_en;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_sof;
  logic       o_eof;
  logic       o_lock;
  logic       o_inverted;
  logic [2:0] o_offset;

  always #5 i_clk = ~i_clk;

  frame_sync #(.FRAME_LEN(FL), .MAX_ERR(2), .CHECK_CNT(2), .MISS_CNT(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data),
    .i_data_valid(i_data_valid), .i_inv_en(i_inv_en),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_sof(o_sof),
    .o_eof(o_eof), .o_lock(o_lock), .o_inverted(o_inverted),
    .o_offset(o_offset)
  );

  typedef struct {
    logic [7:0] d;
    bit         sof;
    bit         eof;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] w;
    bit         ex;
    logic [7:0] d;
    bit         sof;
    bit         eof;
    int         mk;
  } unit_t;

  // errs: 4 bits per marker (bit errors injected); outm: frames expected out
  typedef struct {
    int       k;
    bit       inv_s;
    bit       inv_en;
    int       gap;
    int       nf;
    bit [31:0] errs;
    bit [7:0] outm;
    int       rise_m;
    int       fall_m;
    bit       f_lock;
    bit [2:0] f_off;
    bit       f_inv;
  } scen_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mk_cyc[8];
  int   rise_cyc;
  int   fall_cyc;
  logic [7:0] last_d;
  bit   prev_lock;
  exp_t me;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every payload strobe.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      last_d    = '0;
      prev_lock = 1'b0;
      rise_cyc  = -1;
      fall_cyc  = -1;
    end else begin
      if (o_data_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none t=%0t", o_data, $time);
        end else begin
          me = sbq.pop_front();
          chk("out_data", 32'(o_data), 32'(me.d));
          chk("out_sof", 32'(o_sof), 32'(me.sof));
          chk("out_eof", 32'(o_eof), 32'(me.eof));
          chk("out_latency_cyc", 32'(cyc), 32'(me.cyc));
          last_d = me.d;
        end
      end else begin
        chk("strobe_without_valid", 32'({o_sof, o_eof}), 32'(0));
        chk("data_hold", 32'(o_data), 32'(last_d));
      end
      if (o_lock && !prev_lock && rise_cyc < 0) rise_cyc = cyc;
      if (!o_lock && prev_lock && fall_cyc < 0) fall_cyc = cyc;
      prev_lock = o_lock;
    end
  end

  task automatic put(input logic [7:0] b);
    @(negedge i_clk);
    i_data       = b;
    i_data_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_data_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input bit inv_en);
    @(negedge i_clk);
    i_rst_n      = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_inv_en     = inv_en;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs",
        32'({o_data, o_data_valid, o_sof, o_eof, o_lock, o_inverted, o_offset}), 32'(0));
    i_rst_n = 1'b1;
  endtask

  task automatic run_stream(input scen_t s, input int max_bytes);
    unit_t      uq[$];
    unit_t      u;
    bit         bq[$];
    logic [31:0] mkw;
    logic [7:0] bv;
    exp_t       e;
    int         pre;
    int         ui;
    int         ne;
    for (int i = 0; i < 8; i++) mk_cyc[i] = -1;
    for (int f = 0; f < s.nf; f++) begin
      for (int j = 0; j < FL; j++) begin
        u.d   = 8'(j);
        u.w   = s.inv_s ? ~u.d : u.d;
        u.ex  = s.outm[f];
        u.sof = (j == 0);
        u.eof = (j == FL - 1);
        u.mk  = -1;
        uq.push_back(u);
      end
      ne  = int'((s.errs >> (4 * f)) & 32'hF);
      mkw = ASM_W ^ {8'((1 << ne) - 1), 24'h0};
      for (int b = 0; b < 4; b++) begin
        u.d   = mkw[31 - 8 * b -: 8];
        u.w   = s.inv_s ? ~u.d : u.d;
        u.ex  = 1'b0;
        u.sof = 1'b0;
        u.eof = 1'b0;
        u.mk  = (b == 3) ? f : -1;
        uq.push_back(u);
      end
    end
    pre = (8 - s.k) % 8;
    for (int i = 0; i < pre; i++) bq.push_back(s.inv_s);
    foreach (uq[i]) for (int b = 7; b >= 0; b--) bq.push_back(uq[i].w[b]);
    while (bq.size() % 8 != 0) bq.push_back(s.inv_s);
    ui = 0;
    for (int n = 0; n < bq.size() / 8 && n < max_bytes; n++) begin
      for (int b = 0; b < 8; b++) bv[7 - b] = bq[8 * n + b];
      put(bv);
      while (ui < uq.size() && (pre + 8 * ui + 7) / 8 == n) begin
        if (uq[ui].ex) begin
          e.d   = uq[ui].d;
          e.sof = uq[ui].sof;
          e.eof = uq[ui].eof;
          e.cyc = cyc + 2;
          sbq.push_back(e);
        end
        if (uq[ui].mk >= 0) mk_cyc[uq[ui].mk] = cyc;
        ui++;
      end
      if (s.gap > 0) idle(s.gap);
    end
    idle(6);
  endtask

  task automatic finish_scen(input scen_t s);
    chk("final_lock", 32'(o_lock), 32'(s.f_lock));
    chk("final_offset", 32'(o_offset), 32'(s.f_off));
    chk("final_inverted", 32'(o_inverted), 32'(s.f_inv));
    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
    sbq.delete();
    if (s.rise_m >= 0) chk("lock_rise_cyc", 32'(rise_cyc), 32'(mk_cyc[s.rise_m] + 2));
    else chk("lock_never_rises", 32'(rise_cyc), 32'(-1));
    if (s.fall_m >= 0) chk("lock_fall_cyc", 32'(fall_cyc), 32'(mk_cyc[s.fall_m] + 2));
    else chk("lock_never_falls", 32'(fall_cyc), 32'(-1));
  endtask

  scen_t tab[9];
  scen_t hs;

  initial begin
    // k  inv ie gap nf errs          outm  rise fall lock off inv
    tab[0] = '{3, 0, 0, 0, 4, 32'h0,      8'h08, 2, -1, 1, 3'd3, 0};
    tab[1] = '{3, 0, 0, 2, 4, 32'h0,      8'h08, 2, -1, 1, 3'd3, 0};
    tab[2] = '{3, 1, 1, 0, 4, 32'h0,      8'h08, 2, -1, 1, 3'd3, 1};
    tab[3] = '{3, 1, 0, 0, 4, 32'h0,      8'h00, -1, -1, 0, 3'd0, 0};
    tab[4] = '{3, 0, 0, 0, 6, 32'h2000,   8'h38, 2, -1, 1, 3'd3, 0};
    tab[5] = '{3, 0, 1, 1, 7, 32'h333000, 8'h38, 2, 5, 0, 3'd3, 0};
    tab[6] = '{5, 0, 0, 0, 5, 32'h1,      8'h10, 3, -1, 1, 3'd5, 0};
    tab[7] = '{0, 0, 0, 0, 4, 32'h0,      8'h08, 2, -1, 1, 3'd0, 0};
    tab[8] = '{7, 1, 1, 0, 4, 32'h0,      8'h08, 2, -1, 1, 3'd7, 1};

    i_rst_n      = 1'b0;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_inv_en     = 1'b0;

    for (int t = 0; t < 9; t++) begin
      do_reset(tab[t].inv_en);
      run_stream(tab[t], 1 << 30);
      finish_scen(tab[t]);
    end

    // Asynchronous reset while locked in the middle of a frame, then relock.
    hs      = tab[0];
    hs.nf   = 6;
    hs.outm = 8'h38;
    do_reset(1'b0);
    run_stream(hs, 90);
    chk("pre_reset_lock", 32'(o_lock), 32'(1));
    chk("pre_reset_data", 32'(o_data), 32'(8'h08));
    chk("pre_reset_sb_empty", 32'(sbq.size()), 32'(0));
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           32'({o_data, o_data_valid, o_sof, o_eof, o_lock, o_inverted, o_offset}), 32'(0));
    sbq.delete();
    do_reset(1'b0);
    run_stream(tab[0], 1 << 30);
    finish_scen(tab[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_sync.md
# frame_sync

Byte-stream frame synchronizer that sits directly downstream of the bit-to-byte unpacker (NOB=1) in the receive chain. It searches the unpacked byte stream for a 32-bit attached sync marker at any of 8 bit offsets, in either polarity. It confirms and tracks the marker with a flywheel state machine. Once locked, it emits byte-aligned, polarity-corrected payload bytes with start/end-of-frame strobes to the decoder.

## Interface
- ASM, 32'h1ACFFC1D, sync marker, MSB transmitted first
- FRAME_LEN, 1024, payload bytes between markers (4..65531)
- MAX_ERR, 2, bit errors tolerated on a marker in CHECK/LOCK
- CHECK_CNT, 2, consecutive confirmed markers needed to enter LOCK
- MISS_CNT, 3, consecutive missed markers that drop LOCK
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_data  in  8  unpacked byte, bit 7 oldest
- i_data_valid  in  1  byte strobe, any duty cycle incl. every cycle
- i_inv_en  in  1  also search for ~ASM (phase ambiguity)
- o_data  out  8  aligned payload byte
- o_data_valid  out  1  payload strobe
- o_sof  out  1  with first payload byte of a frame
- o_eof  out  1  with last payload byte of a frame
- o_lock  out  1  state == LOCK
- o_inverted  out  1  latched polarity
- o_offset  out  3  latched bit offset

## Operation
- Window: on i_data_valid, sr[38:0] <= {sr[30:0], i_data}. Candidate k (0..7) = sr[k+31:k]. Aligned byte for k = sr[k+7:k].
- Stage 1 (registered): Hamming distance of each candidate to ASM and to ~ASM, 6 bits each. Also registers window byte and delayed valid. Stage 2: state, counter, outputs.
- States SEARCH, CHECK, LOCK. Reset state: SEARCH.
- SEARCH: a hit requires distance 0. Normal polarity beats inverted; lowest k wins. ~ASM is considered only if i_inv_en=1. On hit: latch k and polarity, byte_cnt<=0, confirm<=0, go to CHECK. No payload output.
- byte_cnt (16 bit) increments per stage-2 valid byte. Payload bytes are cnt 1..FRAME_LEN. Marker evaluation happens at cnt==FRAME_LEN+4, using the latched k and polarity only; after evaluation cnt<=0.
- Marker hit: distance ≤ MAX_ERR.
- CHECK: hit → confirm+1; when confirm reaches CHECK_CNT → LOCK, miss<=0. Miss → SEARCH.
- LOCK: hit → miss<=0. Miss → miss+1; at MISS_CNT → SEARCH, o_lock falls, and the frame following the final miss is not output. Below MISS_CNT, keep flywheeling and outputting.
- Output in LOCK only. Payload starts with the frame after the marker that caused the transition into LOCK. o_data = aligned byte, XOR 8'hFF if inverted. o_sof at cnt==1, o_eof at cnt==FRAME_LEN.
- Re-entering SEARCH clears confirm/miss. The search resumes on the very next byte, so the failing marker bytes themselves can re-hit.
- i_inv_en change takes effect on the next SEARCH only.

## Timing
- Reset (async assert, sync deassert is external): all outputs 0, sr/cnt/confirm/miss 0, SEARCH.
- Latency: o_data_valid asserts exactly 2 clocks after the i_data_valid carrying the byte that completes the aligned payload byte.
- o_data_valid/o_sof/o_eof are single-cycle pulses. o_data holds between pulses.
- No output without input. Gaps in i_data_valid stall all counters; behaviour is independent of gap pattern.
- o_lock rises in the same cycle as the stage-2 evaluation of the CHECK_CNT-th confirming marker, and falls likewise at the MISS_CNT-th miss.
- o_offset/o_inverted update in the cycle SEARCH latches a hit and are held until the next hit.

## Test plan
- FRAME_LEN=16, ASM at bit offset 3, payload 0x00..0x0F, 4 frames → hit at marker 1; o_lock rises at marker 3. Frame 4 is output as 0x00..0x0F, o_offset=3, sof on 0x00, eof on 0x0F, 2-cycle latency.
- Same stream bit-inverted, i_inv_en=1 → o_inverted=1, identical 0x00..0x0F output. With i_inv_en=0 → o_lock never rises.
- Locked, then one marker with 2 bit errors → lock held, payload continues. Three consecutive markers with 3 errors → o_lock falls at the 3rd; no further o_data_valid.
- In SEARCH, a marker with 1 bit error followed by a clean one → first ignored, hit latched on the clean marker.
- i_rst_n low mid-frame while locked → all outputs 0 immediately without clock. After release, reacquires and relocks on schedule.
- i_data_valid every 3rd cycle vs every cycle → identical o_data/o_sof/o_eof sequence.
